// File: rtl/glay_setup_pkg.sv
// rtl/glay_setup_pkg.sv - shared types for the kernel setup unpack stage
package GLAY_SETUP_PKG;

    typedef enum logic [1:0] {
        UNPACK_IDLE    = 2'd0,
        UNPACK_COLLECT = 2'd1,
        UNPACK_HOLD    = 2'd2,
        UNPACK_DONE    = 2'd3
    } kernel_setup_unpack_state;

    localparam int SETUP_LINE_WIDTH = 512;

    // One setup cacheline payload at the default line width.
    typedef logic [SETUP_LINE_WIDTH-1:0] SetupUnpackLine;

endpackage

// File: rtl/glay_kernel_setup_unpack.sv
// rtl/glay_kernel_setup_unpack.sv - collects indexed setup cachelines into one struct
// Optional collection watchdog: GLAY_SETUP_UNPACK_TIMEOUT_EN
module glay_kernel_setup_unpack
    import GLAY_SETUP_PKG::*;
#(
    parameter int NUM_SETUP_CACHELINE = 2,
    parameter int CACHELINE_WIDTH     = 512,
    parameter int INDEX_WIDTH         = 4,
    parameter int TIMEOUT_CYCLES      = 4096
) (
    input  logic                                           ap_clk,
    input  logic                                           areset,
    input  logic                                           setup_start,
    input  logic                                           resp_in_valid,
    input  logic [INDEX_WIDTH-1:0]                         resp_in_index,
    input  logic [CACHELINE_WIDTH-1:0]                     resp_in_data,
    output logic                                           resp_in_ready,
    output logic                                           csr_struct_valid,
    input  logic                                           csr_struct_ready,
    output logic [NUM_SETUP_CACHELINE*CACHELINE_WIDTH-1:0] csr_struct_data,
    output logic                                           setup_done,
    output logic                                           setup_error
);

    localparam int DATA_W = NUM_SETUP_CACHELINE * CACHELINE_WIDTH;
    localparam logic [INDEX_WIDTH:0] NUM_LINES = (INDEX_WIDTH+1)'(NUM_SETUP_CACHELINE);

    kernel_setup_unpack_state state_q, state_d;
    logic [NUM_SETUP_CACHELINE-1:0] bitmap_q, bitmap_d;
    logic                           error_q, error_d;
    logic                           rst_hold_q, rst_hold_d;
    logic [DATA_W-1:0]              data_q, data_d;
    logic                           xfer;
    logic                           idx_ok;
    logic                           dup;

`ifdef GLAY_SETUP_UNPACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // rst_hold_q keeps the block quiet for the first edge after reset release.
    assign resp_in_ready    = !rst_hold_q &&
                              ((state_q == UNPACK_IDLE) || (state_q == UNPACK_COLLECT));
    assign csr_struct_valid = (state_q == UNPACK_HOLD);
    assign setup_done       = (state_q == UNPACK_DONE);
    assign setup_error      = error_q;
    assign csr_struct_data  = data_q;
    assign xfer             = resp_in_valid && resp_in_ready;
    assign idx_ok           = ({1'b0, resp_in_index} < NUM_LINES);

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NUM_SETUP_CACHELINE; i++) begin
            if (resp_in_index == INDEX_WIDTH'(i) && bitmap_q[i]) begin
                dup = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bitmap_d   = bitmap_q;
        error_d    = error_q;
        data_d     = data_q;
        rst_hold_d = 1'b0;
`ifdef GLAY_SETUP_UNPACK_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif

        if (setup_start && state_q != UNPACK_IDLE) begin
            error_d = 1'b1;
        end

        case (state_q)
            UNPACK_IDLE: begin
                if (xfer) begin
                    error_d = 1'b1;
                end
                if (setup_start && !rst_hold_q) begin
                    state_d  = UNPACK_COLLECT;
                    bitmap_d = '0;
`ifdef GLAY_SETUP_UNPACK_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            UNPACK_COLLECT: begin
                if (&bitmap_q) begin
                    state_d = UNPACK_HOLD;
                end
`ifdef GLAY_SETUP_UNPACK_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = UNPACK_IDLE;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
                if (xfer) begin
                    if (!idx_ok || dup) begin
                        error_d = 1'b1;
                    end
                    // Duplicates still overwrite: the newest copy of a line wins.
                    for (int i = 0; i < NUM_SETUP_CACHELINE; i++) begin
                        if (idx_ok && resp_in_index == INDEX_WIDTH'(i)) begin
                            bitmap_d[i] = 1'b1;
                            data_d[i*CACHELINE_WIDTH +: CACHELINE_WIDTH] = resp_in_data;
                        end
                    end
                end
            end
            UNPACK_HOLD: begin
                if (csr_struct_ready) begin
                    state_d = UNPACK_DONE;
                end
            end
            UNPACK_DONE: begin
                state_d = UNPACK_IDLE;
            end
            default: begin
                state_d = UNPACK_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q    <= UNPACK_IDLE;
            bitmap_q   <= '0;
            error_q    <= 1'b0;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bitmap_q   <= bitmap_d;
            error_q    <= error_d;
            rst_hold_q <= rst_hold_d;
        end
    end

`ifdef GLAY_SETUP_UNPACK_TIMEOUT_EN
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Payload storage carries no reset; it is only meaningful in HOLD.
    always_ff @(posedge ap_clk) begin
        data_q <= data_d;
    end

endmodule

// File: tb/tb_glay_kernel_setup_unpack.sv
// tb/tb_glay_kernel_setup_unpack.sv - scoreboard bench for glay_kernel_setup_unpack
module tb_glay_kernel_setup_unpack;
    import GLAY_SETUP_PKG::*;

    localparam int N  = 2;
    localparam int W  = 512;
    localparam int IW = 4;
    localparam int TO = 16;

    logic             ap_clk;
    logic             areset;
    logic             setup_start;
    logic             resp_in_valid;
    logic [IW-1:0]    resp_in_index;
    logic [W-1:0]     resp_in_data;
    logic             resp_in_ready;
    logic             csr_struct_valid;
    logic             csr_struct_ready;
    logic [N*W-1:0]   csr_struct_data;
    logic             setup_done;
    logic             setup_error;

    int vectors = 0;
    int fails   = 0;
    int done_cnt = 0;
    logic [N*W-1:0] exp_q[$];

    glay_kernel_setup_unpack #(
        .NUM_SETUP_CACHELINE(N),
        .CACHELINE_WIDTH    (W),
        .INDEX_WIDTH        (IW),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .ap_clk          (ap_clk),
        .areset          (areset),
        .setup_start     (setup_start),
        .resp_in_valid   (resp_in_valid),
        .resp_in_index   (resp_in_index),
        .resp_in_data    (resp_in_data),
        .resp_in_ready   (resp_in_ready),
        .csr_struct_valid(csr_struct_valid),
        .csr_struct_ready(csr_struct_ready),
        .csr_struct_data (csr_struct_data),
        .setup_done      (setup_done),
        .setup_error     (setup_error)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    function automatic SetupUnpackLine fill(input logic [3:0] nib);
        return {(W/4){nib}};
    endfunction

    // Scoreboard: every struct handoff pops one expected struct.
    always @(negedge ap_clk) begin
        if (!areset && setup_done) done_cnt++;
        if (!areset && csr_struct_valid && csr_struct_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected_handoff got_lo=%h required=none", csr_struct_data[31:0]);
            end else begin
                logic [N*W-1:0] e;
                e = exp_q.pop_front();
                if (csr_struct_data !== e) begin
                    fails++;
                    $display("FAIL sb_struct_data got s1=%h s0=%h required s1=%h s0=%h",
                             csr_struct_data[W +: 32], csr_struct_data[0 +: 32], e[W +: 32], e[0 +: 32]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic pulse_start();
        setup_start = 1'b1;
        tick();
        setup_start = 1'b0;
    endtask

    task automatic send_line(input logic [IW-1:0] idx, input logic [W-1:0] d);
        resp_in_valid = 1'b1;
        resp_in_index = idx;
        resp_in_data  = d;
        tick();
        resp_in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) tick();
        repeat (3) tick();
    endtask

    task automatic apply_reset();
        areset = 1'b1;
        exp_q.delete();
        repeat (2) tick();
        areset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) tick();
        vectors++; if (resp_in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got=%b required=0", resp_in_ready); end
        vectors++; if (csr_struct_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b required=0", csr_struct_valid); end
        vectors++; if (setup_done !== 1'b0) begin fails++; $display("FAIL rst_done got=%b required=0", setup_done); end
        vectors++; if (setup_error !== 1'b0) begin fails++; $display("FAIL rst_error got=%b required=0", setup_error); end
        areset = 1'b0;
        @(negedge ap_clk);
        vectors++; if (resp_in_ready !== 1'b0) begin fails++; $display("FAIL rst_release_ready got=%b required=0", resp_in_ready); end
        tick();
        vectors++; if (resp_in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_rise got=%b required=1", resp_in_ready); end
    endtask

    task automatic test_in_order();
        int d0;
        apply_reset();
        csr_struct_ready = 1'b1;
        d0 = done_cnt;
        exp_q.push_back({fill(4'hB), fill(4'hA)});
        pulse_start();
        send_line(0, fill(4'hA));
        send_line(1, fill(4'hB));
        wait_empty();
        vectors++; if (exp_q.size() != 0) begin fails++; $display("FAIL inorder_handoff got=none required=1"); end
        vectors++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL inorder_done_pulses got=%0d required=1", done_cnt - d0); end
        vectors++; if (setup_error !== 1'b0) begin fails++; $display("FAIL inorder_error got=%b required=0", setup_error); end
        vectors++; if (resp_in_ready !== 1'b1) begin fails++; $display("FAIL inorder_idle_ready got=%b required=1", resp_in_ready); end
    endtask

    task automatic test_out_of_order();
        apply_reset();
        csr_struct_ready = 1'b1;
        exp_q.push_back({fill(4'hB), fill(4'hA)});
        pulse_start();
        send_line(1, fill(4'hB));
        send_line(0, fill(4'hA));
        wait_empty();
        vectors++; if (exp_q.size() != 0) begin fails++; $display("FAIL ooo_handoff got=none required=1"); end
        vectors++; if (setup_error !== 1'b0) begin fails++; $display("FAIL ooo_error got=%b required=0", setup_error); end
    endtask

    task automatic test_duplicate();
        apply_reset();
        csr_struct_ready = 1'b1;
        exp_q.push_back({fill(4'hB), fill(4'h2)});
        pulse_start();
        send_line(0, fill(4'h1));
        send_line(0, fill(4'h2));
        send_line(1, fill(4'hB));
        wait_empty();
        vectors++; if (exp_q.size() != 0) begin fails++; $display("FAIL dup_handoff got=none required=1"); end
        vectors++; if (setup_error !== 1'b1) begin fails++; $display("FAIL dup_error got=%b required=1", setup_error); end
    endtask

    task automatic test_out_of_range();
        apply_reset();
        csr_struct_ready = 1'b1;
        pulse_start();
        send_line(5, fill(4'hF));
        vectors++; if (setup_error !== 1'b1) begin fails++; $display("FAIL oob_error got=%b required=1", setup_error); end
        vectors++; if (resp_in_ready !== 1'b1) begin fails++; $display("FAIL oob_collect_ready got=%b required=1", resp_in_ready); end
        vectors++; if (csr_struct_valid !== 1'b0) begin fails++; $display("FAIL oob_valid got=%b required=0", csr_struct_valid); end
        exp_q.push_back({fill(4'h6), fill(4'h9)});
        send_line(0, fill(4'h9));
        send_line(1, fill(4'h6));
        wait_empty();
        vectors++; if (exp_q.size() != 0) begin fails++; $display("FAIL oob_handoff got=none required=1"); end
    endtask

    task automatic test_backpressure();
        int d0;
        logic [N*W-1:0] e;
        apply_reset();
        csr_struct_ready = 1'b0;
        d0 = done_cnt;
        e = {fill(4'h3), fill(4'hC)};
        exp_q.push_back(e);
        pulse_start();
        send_line(0, fill(4'hC));
        send_line(1, fill(4'h3));
        tick();
        for (int k = 0; k < 10; k++) begin
            vectors++; if (csr_struct_valid !== 1'b1) begin fails++; $display("FAIL bp_valid c%0d got=%b required=1", k, csr_struct_valid); end
            vectors++; if (csr_struct_data !== e) begin fails++; $display("FAIL bp_data c%0d got_lo=%h required_lo=%h", k, csr_struct_data[31:0], e[31:0]); end
            vectors++; if (resp_in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready c%0d got=%b required=0", k, resp_in_ready); end
            tick();
        end
        vectors++; if (done_cnt != d0) begin fails++; $display("FAIL bp_early_done got=%0d required=%0d", done_cnt, d0); end
        csr_struct_ready = 1'b1;
        wait_empty();
        vectors++; if (exp_q.size() != 0) begin fails++; $display("FAIL bp_handoff got=none required=1"); end
        vectors++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL bp_done_pulses got=%0d required=1", done_cnt - d0); end
    endtask

    task automatic test_protocol_errors();
        apply_reset();
        csr_struct_ready = 1'b1;
        send_line(0, fill(4'h4));
        vectors++; if (setup_error !== 1'b1) begin fails++; $display("FAIL idle_line_error got=%b required=1", setup_error); end
        apply_reset();
        vectors++; if (setup_error !== 1'b0) begin fails++; $display("FAIL error_reset_clear got=%b required=0", setup_error); end
        pulse_start();
        pulse_start();
        vectors++; if (setup_error !== 1'b1) begin fails++; $display("FAIL busy_start_error got=%b required=1", setup_error); end
        exp_q.push_back({fill(4'h7), fill(4'h5)});
        send_line(0, fill(4'h5));
        send_line(1, fill(4'h7));
        wait_empty();
        vectors++; if (exp_q.size() != 0) begin fails++; $display("FAIL busy_start_handoff got=none required=1"); end
    endtask

    task automatic test_mid_reset();
        int d0;
        apply_reset();
        csr_struct_ready = 1'b0;
        d0 = done_cnt;
        pulse_start();
        send_line(0, fill(4'hD));
        apply_reset();
        pulse_start();
        send_line(0, fill(4'hD));
        send_line(1, fill(4'hE));
        repeat (3) tick();
        vectors++; if (csr_struct_valid !== 1'b1) begin fails++; $display("FAIL midrst_hold got=%b required=1", csr_struct_valid); end
        apply_reset();
        csr_struct_ready = 1'b1;
        repeat (4) tick();
        vectors++; if (done_cnt != d0) begin fails++; $display("FAIL midrst_no_done got=%0d required=%0d", done_cnt, d0); end
        vectors++; if (csr_struct_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b required=0", csr_struct_valid); end
        vectors++; if (setup_error !== 1'b0) begin fails++; $display("FAIL midrst_error got=%b required=0", setup_error); end
    endtask

    task automatic test_timeout();
        int d0;
        apply_reset();
        csr_struct_ready = 1'b1;
        d0 = done_cnt;
        pulse_start();
        send_line(0, fill(4'h8));
        repeat (5) tick();
        vectors++; if (setup_error !== 1'b0) begin fails++; $display("FAIL to_early_error got=%b required=0", setup_error); end
`ifdef GLAY_SETUP_UNPACK_TIMEOUT_EN
        repeat (15) tick();
        vectors++; if (setup_error !== 1'b1) begin fails++; $display("FAIL to_error got=%b required=1", setup_error); end
        vectors++; if (done_cnt != d0) begin fails++; $display("FAIL to_no_done got=%0d required=%0d", done_cnt, d0); end
`else
        repeat (40) tick();
        exp_q.push_back({fill(4'h1), fill(4'h8)});
        send_line(1, fill(4'h1));
        wait_empty();
        vectors++; if (exp_q.size() != 0) begin fails++; $display("FAIL nto_handoff got=none required=1"); end
        vectors++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL nto_done got=%0d required=1", done_cnt - d0); end
`endif
    endtask

    initial begin
        areset           = 1'b1;
        setup_start      = 1'b0;
        resp_in_valid    = 1'b0;
        resp_in_index    = '0;
        resp_in_data     = '0;
        csr_struct_ready = 1'b0;
        test_reset();
        test_in_order();
        test_out_of_order();
        test_duplicate();
        test_out_of_range();
        test_backpressure();
        test_protocol_errors();
        test_mid_reset();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
